// File: rtl/time_core.sv
// ============================================================================
// Module   : time_core
// Function : BCD time-of-day counter (24h or 12h+PM) advanced by a slow tick,
//            with a set mode for adjusting minutes and hours.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module time_core #(
    parameter int TWELVE_HOUR = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [7:0] secs_bcd,
    output logic [7:0] mins_bcd,
    output logic [7:0] hours_bcd,
    output logic       pm,
    output logic       sec_pulse
);

    typedef enum logic [0:0] {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

    localparam logic [7:0] c_hours_rst = (TWELVE_HOUR != 0) ? 8'h12 : 8'h00;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   valid_q;
    logic                   edge_q;
    logic                   tick_q, tick_d;
    logic [7:0]             secs_q, secs_d;
    logic [7:0]             mins_q, mins_d;
    logic [7:0]             hours_q, hours_d;
    logic                   pm_q, pm_d;
    logic                   pulse_q, pulse_d;

    function automatic logic [7:0] inc60(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) return 8'h00;
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_hr(input logic [7:0] v);
        if (TWELVE_HOUR != 0) begin
            if (v == 8'h12) return 8'h01;
        end else if (v == 8'h23) begin
            return 8'h00;
        end
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // valid_q marks which edge-detector stages hold post-reset samples, so a
    // tick_in already high at reset release never looks like a rising edge.
    assign tick_d = sync_q[SYNC_STAGES-1] & ~edge_q & valid_q[SYNC_STAGES];

    always_comb begin
        state_d = set_mode ? SET : RUN;
        secs_d  = secs_q;
        mins_d  = mins_q;
        hours_d = hours_q;
        pm_d    = pm_q;
        pulse_d = 1'b0;
        if (set_mode) begin
            // Seconds clear on SET entry and stay cleared for the whole set.
            secs_d = 8'h00;
            if (inc_min) mins_d = inc60(mins_q);
            if (inc_hour) begin
                hours_d = inc_hr(hours_q);
                if ((TWELVE_HOUR != 0) && (hours_q == 8'h11)) pm_d = ~pm_q;
            end
        end else if ((state_q == RUN) && tick_q) begin
            pulse_d = 1'b1;
            secs_d  = inc60(secs_q);
            if (secs_q == 8'h59) begin
                mins_d = inc60(mins_q);
                if (mins_q == 8'h59) begin
                    hours_d = inc_hr(hours_q);
                    if ((TWELVE_HOUR != 0) && (hours_q == 8'h11)) pm_d = ~pm_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            sync_q  <= '0;
            valid_q <= '0;
            edge_q  <= 1'b0;
            tick_q  <= 1'b0;
            secs_q  <= 8'h00;
            mins_q  <= 8'h00;
            hours_q <= c_hours_rst;
            pm_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], tick_in};
            valid_q <= {valid_q[SYNC_STAGES-1:0], 1'b1};
            edge_q  <= sync_q[SYNC_STAGES-1];
            tick_q  <= tick_d;
            secs_q  <= secs_d;
            mins_q  <= mins_d;
            hours_q <= hours_d;
            pm_q    <= pm_d;
            pulse_q <= pulse_d;
        end
    end

    assign secs_bcd  = secs_q;
    assign mins_bcd  = mins_q;
    assign hours_bcd = hours_q;
    assign pm        = pm_q;
    assign sec_pulse = pulse_q;

endmodule

`default_nettype wire
